// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 decryptor key/control slice:
// round count, FSM state encoding, round constants and the forward S-box.
package aes_pkg;

   localparam int NR_128 = 10;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EXPAND = 2'd1,
      ST_RUN    = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

   // Round constant for expansion round 1..10.
   function automatic logic [7:0] rcon(input logic [3:0] idx);
      case (idx)
         4'd1:    rcon = 8'h01;
         4'd2:    rcon = 8'h02;
         4'd3:    rcon = 8'h04;
         4'd4:    rcon = 8'h08;
         4'd5:    rcon = 8'h10;
         4'd6:    rcon = 8'h20;
         4'd7:    rcon = 8'h40;
         4'd8:    rcon = 8'h80;
         4'd9:    rcon = 8'h1b;
         4'd10:   rcon = 8'h36;
         default: rcon = 8'h00;
      endcase
   endfunction

   // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      p  = 8'h00;
      aa = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254 (maps 0 to 0, as the S-box requires).
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] p;
      r = 8'h01;
      p = a;
      for (int i = 1; i < 8; i++) begin
         p = gf_mul(p, p);
         r = gf_mul(r, p);
      end
      return r;
   endfunction

   // Forward S-box: field inverse followed by the affine transform.
   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] x;
      x = gf_inv(a);
      return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
               ^ {x[3:0], x[7:4]} ^ 8'h63;
   endfunction

endpackage

// File: rtl/aes_key_expand_step.sv
// One AES-128 key-expansion round, purely combinational:
// RotWord + SubWord on word 3, Rcon into word 0, then the XOR chain.
module aes_key_expand_step
   import aes_pkg::*;
(
   input  logic [127:0] rk_prev,
   input  logic [7:0]   rc,
   output logic [127:0] rk_next
);

   logic [31:0] rot_w;
   logic [31:0] sub_w;
   logic [31:0] w0;
   logic [31:0] w1;
   logic [31:0] w2;
   logic [31:0] w3;

   assign rot_w = {rk_prev[23:0], rk_prev[31:24]};
   assign sub_w = {sbox(rot_w[31:24]), sbox(rot_w[23:16]),
                   sbox(rot_w[15:8]),  sbox(rot_w[7:0])};

   assign w0 = rk_prev[127:96] ^ sub_w ^ {rc, 24'h0};
   assign w1 = rk_prev[95:64] ^ w0;
   assign w2 = rk_prev[63:32] ^ w1;
   assign w3 = rk_prev[31:0]  ^ w2;

   assign rk_next = {w0, w1, w2, w3};

endmodule

// File: rtl/aes_dec_key_ctrl.sv
// Key/control stage for the iterative AES-128 decryptor: expands the cipher
// key forward into 11 round keys, then replays them round 10 down to 0 while
// enabling the datapath. Done marks the cycle in which the datapath PT is valid.
// Handshake: Start is a level sampled only in IDLE; nothing queues while Busy.
// Optional feature: define AES_KEY_CACHE_EN to skip expansion when the same
// key as the last completed expansion is requested again.
module aes_dec_key_ctrl
   import aes_pkg::*;
#(
   parameter int BLOCK_LENGTH = 128,
   parameter int NR           = NR_128
)
(
   input  logic                    CLK,
   input  logic                    RST,
   input  logic                    Start,
   input  logic [BLOCK_LENGTH-1:0] Key,
   output logic [BLOCK_LENGTH-1:0] K_i,
   output logic [3:0]              Round_Number,
   output logic                    En,
   output logic                    Busy,
   output logic                    Done,
   output logic [1:0]              dbg_state
);

   localparam logic [3:0] NR_IDX = 4'(NR);

   state_t                  state;
   state_t                  state_next;
   logic [3:0]              idx;
   logic [BLOCK_LENGTH-1:0] work_key;
   logic [BLOCK_LENGTH-1:0] step_out;
   logic [BLOCK_LENGTH-1:0] rk [0:NR];
   logic                    cache_hit;

`ifdef AES_KEY_CACHE_EN
   logic cache_valid;

   assign cache_hit = cache_valid && (Key == rk[0]);

   // Cache flag: valid once a full expansion finishes, dropped on a new key.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         cache_valid <= 1'b0;
      end else if (state == ST_IDLE && Start && !cache_hit) begin
         cache_valid <= 1'b0;
      end else if (state == ST_EXPAND && idx == NR_IDX) begin
         cache_valid <= 1'b1;
      end
   end
`else
   assign cache_hit = 1'b0;
`endif

   // Single expansion round, fed from the most recently produced round key.
   aes_key_expand_step u_step (
      .rk_prev (work_key),
      .rc      (rcon(idx)),
      .rk_next (step_out)
   );

   // Round-key store read port: the key for the current round.
   assign K_i       = rk[Round_Number];
   assign dbg_state = state;

   // State register.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) state <= ST_IDLE;
      else      state <= state_next;
   end

   // Next-state and state-decoded outputs.
   always_comb begin
      state_next = state;
      En         = 1'b0;
      Busy       = 1'b1;
      Done       = 1'b0;
      case (state)
         ST_IDLE: begin
            Busy = 1'b0;
            if (Start) state_next = cache_hit ? ST_RUN : ST_EXPAND;
         end
         ST_EXPAND: begin
            if (idx == NR_IDX) state_next = ST_RUN;
         end
         ST_RUN: begin
            En = 1'b1;
            if (Round_Number == 4'd0) state_next = ST_DONE;
         end
         ST_DONE: begin
            Done       = 1'b1;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Round-key store write port, expansion index and round counter.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i <= NR; i++) rk[i] <= '0;
         work_key     <= '0;
         idx          <= 4'd0;
         Round_Number <= NR_IDX;
      end else begin
         case (state)
            ST_IDLE: begin
               if (Start && !cache_hit) begin
                  rk[0]    <= Key;
                  work_key <= Key;
                  idx      <= 4'd1;
               end
            end
            ST_EXPAND: begin
               rk[idx]  <= step_out;
               work_key <= step_out;
               idx      <= idx + 4'd1;
            end
            ST_RUN: begin
               // Wrap back to NR so the datapath sits in first-round mode.
               Round_Number <= (Round_Number == 4'd0) ? NR_IDX : Round_Number - 4'd1;
            end
            default: ;
         endcase
      end
   end

endmodule
